// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for the button-conditioning stage in front of solo_squash.
// Holds the auto-repeat state encoding and the counter-width helper.
package input_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        RPT   = 2'b10
    } rpt_state_e;

    localparam int DEFAULT_DEBOUNCE_TICKS = 8;
    localparam int DEFAULT_REPEAT_DELAY   = 0;
    localparam int DEFAULT_REPEAT_TICKS   = 4;

    // One spare bit so a counter sized for n can always hold n-1 without wrapping.
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, tick-qualified debounce counter,
// debounced level with press/release strobes, and an optional hold-to-repeat FSM.
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_TICKS   = DEFAULT_REPEAT_TICKS,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic state_n,
    output logic press,
    output logic release_o
);

    localparam int CW = count_width(DEBOUNCE_TICKS);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_TICKS) ?
                          ((REPEAT_DELAY > 1) ? REPEAT_DELAY : 1) :
                          ((REPEAT_TICKS > 1) ? REPEAT_TICKS : 1);
    localparam int RW = count_width(RMAX);
    localparam bit RPT_ON = REPEAT_EN && (REPEAT_DELAY > 0);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RT_LAST  = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    rpt_state_e    rstate_q, rstate_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        s1_d      = btn_in;
        s2_d      = s1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rstate_d  = rstate_q;
        rcnt_d    = rcnt_q;

        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                stable_d  = s2_q;
                cnt_d     = '0;
                press_d   = s2_q;
                release_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (RPT_ON) begin
            unique case (rstate_q)
                IDLE: begin
                    if (press_d) begin
                        rstate_d = DELAY;
                        rcnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (tick) begin
                        if (rcnt_q == RD_LAST) begin
                            press_d  = 1'b1;
                            rstate_d = RPT;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                RPT: begin
                    if (tick) begin
                        if (rcnt_q == RT_LAST) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                default: begin
                    rstate_d = IDLE;
                    rcnt_d   = '0;
                end
            endcase

            // An accepted release wins over any repeat pulse due on the same edge.
            if (release_d) begin
                press_d  = 1'b0;
                rstate_d = IDLE;
                rcnt_d   = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rstate_q  <= IDLE;
            rcnt_q    <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign state_n   = ~stable_q;
    assign press     = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/input_debounce.sv
// Debounced button front end for solo_squash: one debounce_channel per raw input.
// The release strobe port is release_o because 'release' is a reserved word.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int                  N_INPUTS       = 4,
    parameter int                  DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int                  REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int                  REPEAT_TICKS   = DEFAULT_REPEAT_TICKS,
    parameter logic [N_INPUTS-1:0] REPEAT_MASK    = N_INPUTS'(4'b1100)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N_INPUTS-1:0] btn_in,
    output logic [N_INPUTS-1:0] state_n,
    output logic [N_INPUTS-1:0] press,
    output logic [N_INPUTS-1:0] release_o,
    output logic                any_held
);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_TICKS   (REPEAT_TICKS),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .btn_in    (btn_in[i]),
            .state_n   (state_n[i]),
            .press     (press[i]),
            .release_o (release_o[i])
        );
    end

    assign any_held = |(~state_n);

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: table-driven vectors plus hand-written repeat/reset sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_input_debounce;

    typedef struct {
        logic [3:0] sn;
        logic [3:0] pr;
        logic [3:0] rl;
        logic       any;
        string      tag;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       tk;
        logic [3:0] btn;
        int         reps;
        logic [3:0] sn;
        logic [3:0] pr;
        logic [3:0] rl;
        logic       any;
        string      tag;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] btn_in;
    logic [3:0] state_n;
    logic [3:0] press;
    logic [3:0] release_o;
    logic       any_held;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    input_debounce #(
        .N_INPUTS       (4),
        .DEBOUNCE_TICKS (4),
        .REPEAT_DELAY   (3),
        .REPEAT_TICKS   (2),
        .REPEAT_MASK    (4'b1110)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_in    (btn_in),
        .state_n   (state_n),
        .press     (press),
        .release_o (release_o),
        .any_held  (any_held)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [3:0] sn, input logic [3:0] pr,
                                    input logic [3:0] rl, input logic any, input string tag);
        exp_t e;
        e.sn = sn; e.pr = pr; e.rl = rl; e.any = any; e.tag = tag;
        return e;
    endfunction

    function automatic vec_t v(input logic r, input logic t, input logic [3:0] b, input int n,
                               input logic [3:0] sn, input logic [3:0] pr, input logic [3:0] rl,
                               input logic a, input string tag);
        vec_t x;
        x.rst = r; x.tk = t; x.btn = b; x.reps = n;
        x.sn = sn; x.pr = pr; x.rl = rl; x.any = a; x.tag = tag;
        return x;
    endfunction

    // Drive one cycle of inputs, queue what must appear after the edge, then compare.
    task automatic step(input logic rst, input logic tk, input logic [3:0] b, input exp_t e);
        exp_t got;
        reset  = rst;
        tick   = tk;
        btn_in = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".state_n"}, state_n, got.sn);
        check({got.tag, ".press"}, press, got.pr);
        check({got.tag, ".release"}, release_o, got.rl);
        check({got.tag, ".any_held"}, {3'b000, any_held}, {3'b000, got.any});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hk;
        bit pk;
        reset  = 1'b1;
        tick   = 1'b1;
        btn_in = 4'b0000;

        // All buttons held through reset, accepted together, repeats on masked channels.
        tbl.push_back(v(1, 1, 4'hF, 3, 4'hF, 4'h0, 4'h0, 0, "A.reset"));
        tbl.push_back(v(0, 1, 4'hF, 5, 4'hF, 4'h0, 4'h0, 0, "A.sync"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'hF, 4'h0, 1, "A.accept"));
        tbl.push_back(v(0, 1, 4'hF, 2, 4'h0, 4'h0, 4'h0, 1, "A.delay"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'hE, 4'h0, 1, "A.rpt_first"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 1, "A.gap1"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'hE, 4'h0, 1, "A.rpt2"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 1, "A.gap2"));
        tbl.push_back(v(0, 1, 4'hF, 1, 4'h0, 4'hE, 4'h0, 1, "A.rpt3"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 1, "A.rel_wait"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'h0, 4'hE, 4'h0, 1, "A.rpt4"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 1, "A.gap3"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'h0, 4'hE, 4'h0, 1, "A.rpt5"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 1, "A.gap4"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hF, 4'h0, 4'hF, 0, "A.release"));
        tbl.push_back(v(0, 1, 4'h0, 3, 4'hF, 4'h0, 4'h0, 0, "A.idle"));
        // 3-cycle glitch is rejected; 4-cycle pulse is the shortest accepted.
        tbl.push_back(v(0, 1, 4'h1, 3, 4'hF, 4'h0, 4'h0, 0, "B.glitch"));
        tbl.push_back(v(0, 1, 4'h0, 6, 4'hF, 4'h0, 4'h0, 0, "B.reject"));
        tbl.push_back(v(0, 1, 4'h1, 4, 4'hF, 4'h0, 4'h0, 0, "B.pulse"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hF, 4'h0, 4'h0, 0, "B.pulse_end"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hE, 4'h1, 4'h0, 1, "B.accept"));
        tbl.push_back(v(0, 1, 4'h0, 3, 4'hE, 4'h0, 4'h0, 1, "B.held"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hF, 4'h0, 4'h1, 0, "B.release"));
        tbl.push_back(v(0, 1, 4'h0, 2, 4'hF, 4'h0, 4'h0, 0, "B.idle"));
        // Tick every 4th clock: counters hold between ticks.
        for (int g = 0; g < 3; g++) begin
            tbl.push_back(v(0, 0, 4'h4, 3, 4'hF, 4'h0, 4'h0, 0, "C.gap"));
            tbl.push_back(v(0, 1, 4'h4, 1, 4'hF, 4'h0, 4'h0, 0, "C.tick"));
        end
        tbl.push_back(v(0, 0, 4'h4, 3, 4'hF, 4'h0, 4'h0, 0, "C.gap"));
        tbl.push_back(v(0, 1, 4'h4, 1, 4'hB, 4'h4, 4'h0, 1, "C.accept"));
        for (int g = 0; g < 2; g++) begin
            tbl.push_back(v(0, 0, 4'h0, 3, 4'hB, 4'h0, 4'h0, 1, "C.hold_gap"));
            tbl.push_back(v(0, 1, 4'h0, 1, 4'hB, 4'h0, 4'h0, 1, "C.hold_tick"));
        end
        tbl.push_back(v(0, 0, 4'h0, 3, 4'hB, 4'h0, 4'h0, 1, "C.hold_gap"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hB, 4'h4, 4'h0, 1, "C.rpt_delay"));
        tbl.push_back(v(0, 0, 4'h0, 3, 4'hB, 4'h0, 4'h0, 1, "C.hold_gap"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hF, 4'h0, 4'h4, 0, "C.release"));
        tbl.push_back(v(0, 1, 4'h0, 3, 4'hF, 4'h0, 4'h0, 0, "C.idle"));
        // Two channels rise together and strobe in the same cycle.
        tbl.push_back(v(0, 1, 4'h5, 5, 4'hF, 4'h0, 4'h0, 0, "F.sync"));
        tbl.push_back(v(0, 1, 4'h5, 1, 4'hA, 4'h5, 4'h0, 1, "F.accept"));
        tbl.push_back(v(0, 1, 4'h0, 2, 4'hA, 4'h0, 4'h0, 1, "F.delay"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hA, 4'h4, 4'h0, 1, "F.rpt_first"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hA, 4'h0, 4'h0, 1, "F.gap"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hA, 4'h4, 4'h0, 1, "F.rpt2"));
        tbl.push_back(v(0, 1, 4'h0, 1, 4'hF, 4'h0, 4'h5, 0, "F.release"));
        tbl.push_back(v(0, 1, 4'h0, 2, 4'hF, 4'h0, 4'h0, 0, "F.idle"));

        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                step(tbl[r].rst, tbl[r].tk, tbl[r].btn,
                     mk_exp(tbl[r].sn, tbl[r].pr, tbl[r].rl, tbl[r].any,
                            $sformatf("%s[%0d]", tbl[r].tag, k)));
            end
        end

        // Channel 3 held 20 cycles: press at 5, first repeat at 8, then every 2 until release at 25.
        for (int k = 0; k < 29; k++) begin
            hk = (k >= 5 && k <= 24);
            pk = (k == 5) || (k >= 8 && k <= 24 && ((k - 8) % 2 == 0));
            step(1'b0, 1'b1, (k < 20) ? 4'b1000 : 4'b0000,
                 mk_exp(hk ? 4'b0111 : 4'b1111, pk ? 4'b1000 : 4'b0000,
                        (k == 25) ? 4'b1000 : 4'b0000, hk, $sformatf("D[%0d]", k)));
        end

        // Channel 1 in repeat, one-cycle reset at 10, full re-debounce to 16.
        for (int k = 0; k < 25; k++) begin
            hk = (k >= 5 && k <= 9) || (k >= 16 && k <= 21);
            pk = (k == 5) || (k == 8) || (k == 16) || (k == 19) || (k == 21);
            step((k == 10), 1'b1, (k < 17) ? 4'b0010 : 4'b0000,
                 mk_exp(hk ? 4'b1101 : 4'b1111, pk ? 4'b0010 : 4'b0000,
                        (k == 22) ? 4'b0010 : 4'b0000, hk, $sformatf("E[%0d]", k)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
